// File: rtl/charbuf_fill_engine.sv
// charbuf_fill_engine: clear/scroll fill sequencer sharing the char buffer write port with the CPU (GPU_SCROLL_QUEUE_EN adds a one-deep scroll queue)
module charbuf_fill_engine #(
  parameter int         ROWS      = 30,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         ADDR_W    = 12
) (
  input  logic              clk_cpu,
  input  logic              rst_n,
  input  logic              mode_80col,
  input  logic              clear_screen,
  input  logic              scroll_screen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] char_buf_addr,
  output logic [7:0]        char_buf_data,
  output logic              char_buf_we,
  output logic [4:0]        top_line,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;
  localparam logic [ADDR_W-1:0] LAST40 = ADDR_W'(ROWS * 40 - 1);
  localparam logic [ADDR_W-1:0] LAST80 = ADDR_W'(ROWS * 80 - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] tl, sbase, slast, cnt, cnt_nx, last, last_nx, addr_nx;
  logic [7:0] data_nx;
  logic [4:0] top_nx;
  logic we_nx, busy_nx, done_nx, fin, fin_nx, at_last;
`ifdef GPU_SCROLL_QUEUE_EN
  logic pending, pend_nx;
`endif
  // row base by shift-add: 40t = 32t+8t, 80t = 64t+16t
  assign tl = ADDR_W'(top_line);
  assign sbase = mode_80col ? (tl << 6) + (tl << 4) : (tl << 5) + (tl << 3);
  assign slast = sbase + (mode_80col ? ADDR_W'(79) : ADDR_W'(39));
  assign at_last = cnt == last;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    last_nx = last;
    top_nx = top_line;
    fin_nx = 1'b0;
    busy_nx = busy;
    done_nx = 1'b0;
    we_nx = cpu_we;
    addr_nx = cpu_we ? cpu_addr : char_buf_addr;
    data_nx = cpu_we ? cpu_data : char_buf_data;
`ifdef GPU_SCROLL_QUEUE_EN
    pend_nx = pending | (state == SCROLL && scroll_screen);
`endif
    if (clear_screen) begin
      state_nx = CLEAR;
      cnt_nx = '0;
      last_nx = mode_80col ? LAST80 : LAST40;
      top_nx = '0;
      busy_nx = 1'b1;
`ifdef GPU_SCROLL_QUEUE_EN
      pend_nx = 1'b0;
`endif
    end else if (scroll_screen && state == IDLE) begin
      state_nx = SCROLL;
      cnt_nx = sbase;
      last_nx = slast;
      busy_nx = 1'b1;
    end else if (fin) begin
      done_nx = 1'b1;
`ifdef GPU_SCROLL_QUEUE_EN
      // queued scroll restarts from the already advanced top_line
      if (state == SCROLL && pend_nx) begin
        cnt_nx = sbase;
        last_nx = slast;
        pend_nx = 1'b0;
      end else
`endif
      begin
        state_nx = IDLE;
        busy_nx = 1'b0;
      end
    end else if (state != IDLE && !cpu_we) begin
      we_nx = 1'b1;
      addr_nx = cnt;
      data_nx = FILL_CHAR;
      fin_nx = at_last;
      cnt_nx = at_last ? cnt : cnt + 1'b1;
      if (at_last && state == SCROLL) top_nx = top_line == 5'(ROWS - 1) ? '0 : top_line + 5'd1;
    end
  end
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= '0;
      fin <= 1'b0;
      top_line <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      char_buf_we <= 1'b0;
      char_buf_addr <= '0;
      char_buf_data <= '0;
`ifdef GPU_SCROLL_QUEUE_EN
      pending <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      last <= last_nx;
      fin <= fin_nx;
      top_line <= top_nx;
      busy <= busy_nx;
      done <= done_nx;
      char_buf_we <= we_nx;
      char_buf_addr <= addr_nx;
      char_buf_data <= data_nx;
`ifdef GPU_SCROLL_QUEUE_EN
      pending <= pend_nx;
`endif
    end
  end
endmodule

// File: tb/tb_charbuf_fill_engine.sv
// tb_charbuf_fill_engine: randomized bench against a queue-based model of the fill engine
module tb_charbuf_fill_engine;
  logic clk_cpu = 1'b0;
  logic rst_n, mode_80col, clear_screen, scroll_screen, cpu_we;
  logic [11:0] cpu_addr, char_buf_addr;
  logic [7:0] cpu_data, char_buf_data;
  logic char_buf_we, busy, done;
  logic [4:0] top_line;
  int n_chk = 0, n_err = 0;
  int m_op = 0, m_top = 0;
  bit m_tail = 0, m_pend = 0, m_busy = 0, rnd_cpu = 0;
  int q[$];
  bit e_we, e_done;
  int e_addr, e_data;
  int n_fill, n_busy, n_done;

  charbuf_fill_engine dut (
    .clk_cpu(clk_cpu), .rst_n(rst_n), .mode_80col(mode_80col),
    .clear_screen(clear_screen), .scroll_screen(scroll_screen),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we),
    .char_buf_addr(char_buf_addr), .char_buf_data(char_buf_data), .char_buf_we(char_buf_we),
    .top_line(top_line), .busy(busy), .done(done)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    m_op = 0; m_top = 0; m_tail = 0; m_pend = 0; m_busy = 0; q.delete();
  endtask

  task automatic start_scroll(input int cols);
    m_op = 2; m_busy = 1; q.delete();
    for (int i = 0; i < cols; i++) q.push_back(m_top * cols + i);
  endtask

  task automatic cyc(input logic clr, input logic scr, input logic we, input logic [11:0] a, input logic [7:0] d);
    int cols;
    clear_screen = clr; scroll_screen = scr; cpu_we = we; cpu_addr = a; cpu_data = d;
    cols = mode_80col ? 80 : 40;
    @(posedge clk_cpu);
    e_we = 0; e_done = 0;
    if (we) begin e_we = 1; e_addr = a; e_data = d; end
`ifdef GPU_SCROLL_QUEUE_EN
    if (m_op == 2 && scr) m_pend = 1;
`endif
    if (clr) begin
      m_op = 1; m_top = 0; m_busy = 1; m_tail = 0; m_pend = 0; q.delete();
      for (int i = 0; i < 30 * cols; i++) q.push_back(i);
    end else if (scr && m_op == 0) start_scroll(cols);
    else if (m_op != 0 && m_tail) begin
      e_done = 1; m_tail = 0;
      if (m_op == 2 && m_pend) begin m_pend = 0; start_scroll(cols); end
      else begin m_op = 0; m_busy = 0; end
    end else if (m_op != 0 && !we) begin
      e_we = 1; e_addr = q.pop_front(); e_data = 8'h20;
      if (q.size() == 0) begin
        m_tail = 1;
        if (m_op == 2) m_top = (m_top + 1) % 30;
      end
    end
    #1;
    check("we", char_buf_we, e_we);
    if (e_we) begin
      check("addr", char_buf_addr, e_addr);
      check("data", char_buf_data, e_data);
    end
    check("busy", busy, m_busy);
    check("done", done, e_done);
    check("top", top_line, m_top);
    if (char_buf_we && !we) n_fill++;
    if (busy) n_busy++;
    if (done) n_done++;
    @(negedge clk_cpu);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, rnd_cpu && $urandom_range(0, 7) == 0, 12'($urandom), 8'($urandom));
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (m_op != 0 && n < limit) begin idle_cyc(); n++; end
    check("idle_timeout", m_op, 0);
    repeat (2) idle_cyc();
  endtask

  task automatic clr_cnt();
    n_fill = 0; n_busy = 0; n_done = 0;
  endtask

  initial begin
    rst_n = 0; mode_80col = 0; clear_screen = 0; scroll_screen = 0;
    cpu_we = 0; cpu_addr = 0; cpu_data = 0;
    #12;
    check("rst_we", char_buf_we, 0);
    check("rst_addr", char_buf_addr, 0);
    check("rst_data", char_buf_data, 0);
    check("rst_top", top_line, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk_cpu);
    rst_n = 1;
    idle_cyc();
    // full 40-column clear
    clr_cnt();
    cyc(1, 0, 0, 0, 0);
    wait_idle(3000);
    check("clr40_fills", n_fill, 1200);
    check("clr40_busy", n_busy, 1201);
    check("clr40_done", n_done, 1);
    // 29 scrolls then an 80-column scroll from the last row
    for (int i = 0; i < 29; i++) begin cyc(0, 1, 0, 0, 0); wait_idle(200); end
    check("top29", top_line, 29);
    mode_80col = 1;
    clr_cnt();
    cyc(0, 1, 0, 0, 0);
    while (m_op != 0 && q.size() > 0 && q[0] != 2320) idle_cyc();
    check("scr80_first", q.size(), 80);
    wait_idle(200);
    check("scr80_fills", n_fill, 80);
    check("scr80_top", top_line, 0);
    check("scr80_done", n_done, 1);
    // CPU write injected at counter 10
    mode_80col = 0;
    clr_cnt();
    cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 50 && !(q.size() > 0 && q[0] == 10 && !m_tail); n++) idle_cyc();
    cyc(0, 0, 1, 12'd5, 8'h41);
    check("inj_addr", char_buf_addr, 5);
    check("inj_data", char_buf_data, 8'h41);
    idle_cyc();
    check("resume_addr", char_buf_addr, 10);
    wait_idle(3000);
    check("inj_fills", n_fill, 1200);
    // simultaneous clear and scroll
    cyc(0, 1, 0, 0, 0); wait_idle(200);
    clr_cnt();
    cyc(1, 1, 0, 0, 0);
    wait_idle(3000);
    check("both_top", top_line, 0);
    check("both_fills", n_fill, 1200);
    // clear aborts an 80-column scroll at top_line 3
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 0, 0, 0); wait_idle(200); end
    mode_80col = 1;
    cyc(0, 1, 0, 0, 0);
    for (int n = 0; n < 200 && q.size() > 40; n++) idle_cyc();
    clr_cnt();
    cyc(1, 0, 0, 0, 0);
    wait_idle(3000);
    check("abort_top", top_line, 0);
    check("abort_fills", n_fill, 2400);
    // two scrolls 5 cycles apart
    mode_80col = 0;
    clr_cnt();
    cyc(0, 1, 0, 0, 0);
    repeat (4) idle_cyc();
    cyc(0, 1, 0, 0, 0);
    wait_idle(300);
`ifdef GPU_SCROLL_QUEUE_EN
    check("q_top", top_line, 2);
    check("q_done", n_done, 2);
    check("q_fills", n_fill, 80);
`else
    check("q_top", top_line, 1);
    check("q_done", n_done, 1);
    check("q_fills", n_fill, 40);
`endif
    // randomized traffic, random mode per cycle
    rnd_cpu = 1;
    for (int i = 0; i < 15000; i++) begin
      mode_80col = 1'($urandom);
      cyc($urandom_range(0, 3999) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 7) == 0, 12'($urandom), 8'($urandom));
    end
    // async reset in the middle of a clear
    cyc(1, 0, 0, 0, 0);
    repeat (100) idle_cyc();
    rst_n = 0;
    #1;
    m_reset();
    check("arst_busy", busy, 0);
    check("arst_we", char_buf_we, 0);
    check("arst_addr", char_buf_addr, 0);
    check("arst_top", top_line, 0);
    @(negedge clk_cpu);
    rst_n = 1;
    repeat (5) idle_cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/charbuf_fill_engine.md
Name: charbuf_fill_engine

Overview:
- Hardware clear/scroll sequencer for the 80x30 character buffer write port, in the CPU clock domain.
- Replaces the CPU software loops for clearing the screen and for clearing a line on scroll. Consumes the clear_screen/scroll_screen pulses from gpu_registers.
- Owns the circular-buffer top_line pointer.
- Arbitrates the single buffer write port between CPU character writes and engine fill writes.

Parameters:
ROWS, 30, text rows; top_line wraps modulo ROWS
FILL_CHAR, 8'h20, code written by clear/scroll (space)
ADDR_W, 12, character buffer address width

Ports:
clk_cpu  in  1  system clock
rst_n  in  1  async active-low reset
mode_80col  in  1  0=40 columns, 1=80 columns; sampled at operation start
clear_screen  in  1  1-cycle clear request pulse
scroll_screen  in  1  1-cycle scroll request pulse
cpu_addr  in  ADDR_W  CPU write address
cpu_data  in  8  CPU write data
cpu_we  in  1  CPU write strobe
char_buf_addr  out  ADDR_W  write address to character buffer
char_buf_data  out  8  write data to character buffer
char_buf_we  out  1  write enable to character buffer
top_line  out  5  physical row shown at screen row 0
busy  out  1  engine operation in progress
done  out  1  1-cycle pulse after an operation completes

Behaviour:
- Reset values: top_line=0, busy=0, done=0, char_buf_we=0, char_buf_addr=0, char_buf_data=0, state=IDLE, pending=0.
- All outputs are registered.
- Address map: addr = row*cols + col, where cols = 40 or 80 per the latched mode. Row base is computed by adding cols per row, no multiplier.
- States: IDLE, CLEAR, SCROLL.
- IDLE -> CLEAR on clear_screen:
  - latch cols, set addr counter=0, set top_line=0;
  - busy=1 and first fill write on the next cycle.
  - The start cycle is also used for the top_line update, so the first write appears 2 cycles after the pulse.
- IDLE -> SCROLL on scroll_screen:
  - latch cols;
  - addr counter = top_line*cols;
  - writes FILL_CHAR to cols consecutive addresses.
- End of CLEAR: last write to ROWS*cols-1, i.e. 1200 writes (40-col) or 2400 writes (80-col).
- End of SCROLL: on the last write, top_line <= (top_line==ROWS-1) ? 0 : top_line+1.
- Exit to IDLE: the cycle after the last write, busy=0 and done=1 for exactly one cycle.
- Arbitration:
  - cpu_we has absolute priority; the CPU write is forwarded with one-cycle latency.
  - The engine stalls that cycle: counter unchanged, no fill write.
  - A CPU write in IDLE passes through identically.
  - Exactly one write per cycle reaches the buffer.
- Simultaneous clear_screen and scroll_screen: clear wins; the scroll is discarded.
- clear_screen while in CLEAR: restart from address 0.
- clear_screen while in SCROLL: abort the scroll; top_line is not incremented; pending is cleared; CLEAR starts.
- scroll_screen while in CLEAR: discarded.
- scroll_screen while in SCROLL: see the optional feature.
- mode_80col changes mid-operation are ignored until the next start.
- Async reset mid-operation: immediate return to reset values; the partially filled buffer is left as is.
- Counters never exceed 2399; there is no wrap beyond the buffer.

Optional Feature:
- Macro GPU_SCROLL_QUEUE_EN.
- Defined: a one-deep pending flag.
  - scroll_screen during SCROLL sets pending.
  - At SCROLL completion with pending set, done pulses and the next SCROLL starts the following cycle using the updated top_line. busy stays 1 throughout.
  - Further requests while pending=1 are dropped.
- Undefined: scroll_screen during SCROLL is dropped; no pending state is built.

Test Plan:
- Reset, mode_80col=0, clear_screen pulse -> exactly 1200 writes of 8'h20 to addresses 0..1199; top_line=0; busy high for 1201 cycles after first pulse-response cycle; done pulses once; no write to address 1200.
- top_line=29 (after 29 scrolls), mode_80col=1, scroll_screen -> 80 writes of 8'h20 to addresses 2320..2399, then top_line=0 and done pulse.
- cpu_we with addr=5, data=8'h41 injected during CLEAR at counter 10 -> buffer sees 0x41@5 that cycle; fill stalls one cycle and resumes at 10; total fill writes still 1200.
- clear_screen and scroll_screen asserted in the same cycle from IDLE -> CLEAR only; top_line=0; no scroll follows.
- clear_screen at the 40th write of an 80-col SCROLL with top_line=3 -> scroll aborts; top_line becomes 0 (not 4); full 2400-write clear.
- With GPU_SCROLL_QUEUE_EN, two scroll pulses 5 cycles apart (40-col, top_line=0) -> rows 0 then 1 cleared (addresses 0..39, then 40..79); top_line=2; two done pulses; busy continuously high. Without the macro -> only row 0 cleared; top_line=1.
